// File: rtl/bit_serial_adder_tree_param_if.sv
// Serial operand/result bundle for the bit-serial adder tree.
// master = operand source (shifters), slave = the adder tree.
interface bit_serial_adder_tree_param_if #(
  parameter int N_INPUTS = 8
);
  logic                in_valid;
  logic                clean;
  logic [N_INPUTS-1:0] inputs;
  logic [N_INPUTS-1:0] sub_mask;
  logic                result;
  logic                out_valid;
  logic                out_last;
  logic                err_frame;

  modport master (
    output in_valid, clean, inputs, sub_mask,
    input  result, out_valid, out_last, err_frame
  );

  modport slave (
    input  in_valid, clean, inputs, sub_mask,
    output result, out_valid, out_last, err_frame
  );
endinterface

// File: rtl/bit_serial_adder_tree_param.sv
// LSB-first bit-serial adder tree: sums N_INPUTS serial two's-complement words,
// each optionally negated, with valid/last tags carried alongside the data.
module bit_serial_adder_tree_param #(
  parameter int N_INPUTS  = 8,
  parameter int WORD_BITS = 32,
  parameter int PIPE      = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  bit_serial_adder_tree_param_if.slave  bus
);
  localparam int LEVELS = $clog2(N_INPUTS);
  localparam int HALF   = N_INPUTS / 2;
  localparam int CW     = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_BITS - 1);

  logic [CW-1:0]       bcnt_q, bcnt_d;
  logic [N_INPUTS-1:0] mask_q, mask_d;
  logic [N_INPUTS-1:0] seen1_q, seen1_d;
  logic                err_q, err_d;

  logic [LEVELS-1:0][HALF-1:0] carry_q, carry_d;
  logic [LEVELS-1:0][HALF-1:0] stage_q, stage_d;
  logic [LEVELS-1:0]           vtag_q, vtag_d;
  logic [LEVELS-1:0]           ltag_q, ltag_d;

  logic res_q, res_d;
  logic ov_q, ov_d;
  logic ol_q, ol_d;

  logic                word_end;
  logic [N_INPUTS-1:0] eff_mask;
  logic [N_INPUTS-1:0] neg_bits;

  // Framing, mask capture and per-operand serial negation.
  // A word ends on clean or on its last counted bit, so a framing error still
  // leaves the counter, carries and negators ready for a fresh word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    word_end = bus.in_valid && (bus.clean || (bcnt_q == LAST_IDX));
    eff_mask = (bcnt_q == '0) ? bus.sub_mask : mask_q;
    neg_bits = bus.inputs ^ (eff_mask & seen1_q);
    bcnt_d   = bcnt_q;
    mask_d   = mask_q;
    seen1_d  = seen1_q;
    err_d    = err_q;
    if (bus.in_valid) begin
      if (bcnt_q == '0) mask_d = bus.sub_mask;
      if (word_end) begin
        bcnt_d  = '0;
        seen1_d = '0;
      end else begin
        bcnt_d  = bcnt_q + CW'(1);
        seen1_d = seen1_q | bus.inputs;
      end
      if (bus.clean != (bcnt_q == LAST_IDX)) err_d = 1'b1;
    end
  end

  // Tree of serial full adders; tags follow the data through each optional stage.
  always_comb begin
    logic [N_INPUTS-1:0] cur_data;
    logic [HALF-1:0]     sum_bits;
    logic                cur_valid;
    logic                cur_last;
    logic                a, b, c;
    cur_data  = neg_bits;
    cur_valid = bus.in_valid;
    cur_last  = word_end;
    sum_bits  = '0;
    a         = 1'b0;
    b         = 1'b0;
    c         = 1'b0;
    carry_d   = carry_q;
    stage_d   = stage_q;
    vtag_d    = '0;
    ltag_d    = '0;
    for (int l = 0; l < LEVELS; l++) begin
      sum_bits = '0;
      for (int j = 0; j < HALF; j++) begin
        if (j < (N_INPUTS >> (l + 1))) begin
          a           = cur_data[2*j];
          b           = cur_data[2*j+1];
          c           = carry_q[l][j];
          sum_bits[j] = a ^ b ^ c;
          // Carry dies after this node's own last bit so words never mix.
          if (cur_valid) carry_d[l][j] = !cur_last && ((a & b) | (a & c) | (b & c));
        end
      end
      if ((PIPE != 0) && (l < LEVELS - 1)) begin
        if (cur_valid) stage_d[l] = sum_bits;
        vtag_d[l] = cur_valid;
        ltag_d[l] = cur_valid && cur_last;
        cur_data  = {{(N_INPUTS - HALF){1'b0}}, stage_q[l]};
        cur_valid = vtag_q[l];
        cur_last  = ltag_q[l];
      end else begin
        cur_data = {{(N_INPUTS - HALF){1'b0}}, sum_bits};
      end
    end
    // The output register doubles as the final pipe stage; result holds across bubbles.
    res_d = cur_valid ? cur_data[0] : res_q;
    ov_d  = cur_valid;
    ol_d  = cur_valid && cur_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every flop is reset, so a partial word cannot reappear after reset.
      bcnt_q  <= '0;
      mask_q  <= '0;
      seen1_q <= '0;
      err_q   <= 1'b0;
      carry_q <= '0;
      stage_q <= '0;
      vtag_q  <= '0;
      ltag_q  <= '0;
      res_q   <= 1'b0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all stages advance on the same edge.
      bcnt_q  <= bcnt_d;
      mask_q  <= mask_d;
      seen1_q <= seen1_d;
      err_q   <= err_d;
      carry_q <= carry_d;
      stage_q <= stage_d;
      vtag_q  <= vtag_d;
      ltag_q  <= ltag_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
    end
  end

  assign bus.result    = res_q;
  assign bus.out_valid = ov_q;
  assign bus.out_last  = ol_q;
  assign bus.err_frame = err_q;
endmodule
